vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 206 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with an internal
// pixel clock-enable. Optional frame-buffer prefetch counters are built when
// the VGA_PREFETCH_EN macro is defined; otherwise req_* are tied to 0.
module vga_timing_gen #(
  parameter int unsigned CW       = 11,
  parameter int unsigned DIV      = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned LEAD     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic          hs,
  output logic          vs,
  output logic          blank_n,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          line_start,
  output logic          frame_start,
  output logic          frame_end,
  output logic          req_valid,
  output logic [CW-1:0] req_col,
  output logic [CW-1:0] req_row
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] FE_H     = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] FE_V     = CW'(V_ACTIVE - 1);
  localparam logic          HS_ON    = 1'(HS_POL);
  localparam logic          VS_ON    = 1'(VS_POL);

  // Reject configurations the counters cannot represent
  if (DIV == 0 || LEAD == 0 || LEAD >= H_FP + H_SYNC + H_BP) begin : g_bad_cfg
    $error("vga_timing_gen: DIV must be >= 1 and LEAD within the horizontal blanking");
  end

  // One raster step: advance h, wrap to next line, wrap to next frame
  function automatic logic [2*CW-1:0] f_step(input logic [CW-1:0] h, input logic [CW-1:0] v);
    logic [CW-1:0] h_n;
    logic [CW-1:0] v_n;
    h_n = h + CW'(1);
    v_n = v;
    if (h == H_LAST) begin
      h_n = '0;
      v_n = (v == V_LAST) ? '0 : v + CW'(1);
    end
    return {h_n, v_n};
  endfunction

  logic [DW-1:0] r_div, w_div_d;
  logic          r_run, w_run_d;
  logic [CW-1:0] r_h, r_v, w_h_d, w_v_d;
  logic          r_pix_ce, w_pix_ce_d;
  logic          r_hs, w_hs_d, r_vs, w_vs_d, r_blank_n, w_blank_n_d;
  logic          r_line_start, w_line_start_d;
  logic          r_frame_start, w_frame_start_d;
  logic          r_frame_end, w_frame_end_d;
  logic          w_tick;
`ifdef VGA_PREFETCH_EN
  logic [CW-1:0] r_lh, r_lv, w_lh_d, w_lv_d;
  logic          r_req_valid, w_req_valid_d;
`endif

  assign w_tick = en && (r_div == DIV_LAST);

  // Next state: divider, raster counters and decodes taken from the next position
  always_comb begin
    w_div_d         = r_div;
    w_run_d         = r_run;
    w_h_d           = r_h;
    w_v_d           = r_v;
    w_pix_ce_d      = 1'b0;
    w_hs_d          = r_hs;
    w_vs_d          = r_vs;
    w_blank_n_d     = r_blank_n;
    w_line_start_d  = 1'b0;
    w_frame_start_d = 1'b0;
    w_frame_end_d   = 1'b0;
`ifdef VGA_PREFETCH_EN
    w_lh_d          = r_lh;
    w_lv_d          = r_lv;
    w_req_valid_d   = r_req_valid;
`endif
    if (!en) begin
      w_div_d     = '0;
      w_run_d     = 1'b0;
      w_h_d       = '0;
      w_v_d       = '0;
      w_hs_d      = ~HS_ON;
      w_vs_d      = ~VS_ON;
      w_blank_n_d = 1'b0;
`ifdef VGA_PREFETCH_EN
      w_lh_d        = '0;
      w_lv_d        = '0;
      w_req_valid_d = 1'b0;
`endif
    end else begin
      w_div_d = (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
      if (w_tick) begin
        // First tick after enable presents (0,0) without advancing
        w_run_d    = 1'b1;
        w_pix_ce_d = 1'b1;
        if (r_run) begin
          {w_h_d, w_v_d} = f_step(r_h, r_v);
        end else begin
          {w_h_d, w_v_d} = '0;
        end
        w_hs_d          = (w_h_d >= HS_BEG && w_h_d < HS_END) ? HS_ON : ~HS_ON;
        w_vs_d          = (w_v_d >= VS_BEG && w_v_d < VS_END) ? VS_ON : ~VS_ON;
        w_blank_n_d     = (w_h_d < H_ACT) && (w_v_d < V_ACT);
        w_line_start_d  = (w_h_d == '0);
        w_frame_start_d = (w_h_d == '0) && (w_v_d == '0);
        w_frame_end_d   = (w_h_d == FE_H) && (w_v_d == FE_V);
`ifdef VGA_PREFETCH_EN
        if (r_run) begin
          {w_lh_d, w_lv_d} = f_step(r_lh, r_lv);
        end else begin
          {w_lh_d, w_lv_d} = {CW'(LEAD), CW'(0)};
        end
        w_req_valid_d = (w_lh_d < H_ACT) && (w_lv_d < V_ACT);
`endif
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div         <= '0;
      r_run         <= 1'b0;
      r_h           <= '0;
      r_v           <= '0;
      r_pix_ce      <= 1'b0;
      r_hs          <= ~HS_ON;
      r_vs          <= ~VS_ON;
      r_blank_n     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
`ifdef VGA_PREFETCH_EN
      r_lh          <= '0;
      r_lv          <= '0;
      r_req_valid   <= 1'b0;
`endif
    end else begin
      r_div         <= w_div_d;
      r_run         <= w_run_d;
      r_h           <= w_h_d;
      r_v           <= w_v_d;
      r_pix_ce      <= w_pix_ce_d;
      r_hs          <= w_hs_d;
      r_vs          <= w_vs_d;
      r_blank_n     <= w_blank_n_d;
      r_line_start  <= w_line_start_d;
      r_frame_start <= w_frame_start_d;
      r_frame_end   <= w_frame_end_d;
`ifdef VGA_PREFETCH_EN
      r_lh          <= w_lh_d;
      r_lv          <= w_lv_d;
      r_req_valid   <= w_req_valid_d;
`endif
    end
  end

  assign pix_ce      = r_pix_ce;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank_n     = r_blank_n;
  assign col         = r_h;
  assign row         = r_v;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
`ifdef VGA_PREFETCH_EN
  assign req_valid   = r_req_valid;
  assign req_col     = r_lh;
  assign req_row     = r_lv;
`else
  assign req_valid   = 1'b0;
  assign req_col     = '0;
  assign req_row     = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. Four instances share
// clk/rst: default timing, default horizontal with a short vertical frame,
// the same with inverted sync polarity, and a tiny DIV=1 raster.
module tb_vga_timing_gen;

  localparam int unsigned CW = 11;
  localparam int unsigned SW = 4;

  localparam logic [28:0] D_RST   = {7'b0110000, 22'd0};
  localparam logic [28:0] D_START = {7'b1111110, 22'd0};

  logic clk = 1'b0;
  logic rst, en_a, en_s;

  always #5 clk = ~clk;

  logic d_pix, d_hs, d_vs, d_blank, d_ls, d_fs, d_fe, d_rv;
  logic [CW-1:0] d_col, d_row, d_rc, d_rr;
  logic m_pix, m_hs, m_vs, m_blank, m_ls, m_fs, m_fe, m_rv;
  logic [CW-1:0] m_col, m_row, m_rc, m_rr;
  logic p_pix, p_hs, p_vs, p_blank, p_ls, p_fs, p_fe, p_rv;
  logic [CW-1:0] p_col, p_row, p_rc, p_rr;
  logic s_pix, s_hs, s_vs, s_blank, s_ls, s_fs, s_fe, s_rv;
  logic [SW-1:0] s_col, s_row, s_rc, s_rr;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .en(en_a), .pix_ce(d_pix), .hs(d_hs), .vs(d_vs),
    .blank_n(d_blank), .col(d_col), .row(d_row), .line_start(d_ls),
    .frame_start(d_fs), .frame_end(d_fe), .req_valid(d_rv), .req_col(d_rc), .req_row(d_rr));

  vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_mid (
    .clk(clk), .rst(rst), .en(en_a), .pix_ce(m_pix), .hs(m_hs), .vs(m_vs),
    .blank_n(m_blank), .col(m_col), .row(m_row), .line_start(m_ls),
    .frame_start(m_fs), .frame_end(m_fe), .req_valid(m_rv), .req_col(m_rc), .req_row(m_rr));

  vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .HS_POL(1), .VS_POL(1)) u_pol (
    .clk(clk), .rst(rst), .en(en_a), .pix_ce(p_pix), .hs(p_hs), .vs(p_vs),
    .blank_n(p_blank), .col(p_col), .row(p_row), .line_start(p_ls),
    .frame_start(p_fs), .frame_end(p_fe), .req_valid(p_rv), .req_col(p_rc), .req_row(p_rr));

  vga_timing_gen #(.CW(SW), .DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_sml (
    .clk(clk), .rst(rst), .en(en_s), .pix_ce(s_pix), .hs(s_hs), .vs(s_vs),
    .blank_n(s_blank), .col(s_col), .row(s_row), .line_start(s_ls),
    .frame_start(s_fs), .frame_end(s_fe), .req_valid(s_rv), .req_col(s_rc), .req_row(s_rr));

  logic [28:0] d_vec, m_vec, p_inv;
  logic [14:0] s_vec;
  assign d_vec = {d_pix, d_hs, d_vs, d_blank, d_ls, d_fs, d_fe, d_col, d_row};
  assign m_vec = {m_pix, m_hs, m_vs, m_blank, m_ls, m_fs, m_fe, m_col, m_row};
  assign p_inv = {p_pix, ~p_hs, ~p_vs, p_blank, p_ls, p_fs, p_fe, p_col, p_row};
  assign s_vec = {s_pix, s_hs, s_vs, s_blank, s_ls, s_fs, s_fe, s_col, s_row};

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef VGA_PREFETCH_EN
  // Reference position two pixel ticks ahead, with active-video flag
  function automatic logic [63:0] f_lead(input int unsigned c, input int unsigned r,
                                         input int unsigned ht, input int unsigned vt,
                                         input int unsigned ha, input int unsigned va);
    int unsigned lc, lr;
    lc = c + 2;
    lr = r;
    if (lc >= ht) begin
      lc = lc - ht;
      lr = (r + 1) % vt;
    end
    return {31'd0, 1'(lc < ha && lr < va), 16'(lc), 16'(lr)};
  endfunction
`endif

  // Small-raster vectors: flags = {pix_ce, hs, vs, blank_n, line_start, frame_start, frame_end}
  typedef struct {
    logic          en;
    logic [6:0]    flg;
    logic [SW-1:0] col;
    logic [SW-1:0] row;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int n, bad, blanks, vlow, lsn, fen, febad, rqbad, fsnols;

    tbl[0]  = '{1'b0, 7'b0110000, 4'd0, 4'd0};
    tbl[1]  = '{1'b0, 7'b0110000, 4'd0, 4'd0};
    tbl[2]  = '{1'b1, 7'b1111110, 4'd0, 4'd0};
    tbl[3]  = '{1'b1, 7'b1111000, 4'd1, 4'd0};
    tbl[4]  = '{1'b1, 7'b1111000, 4'd2, 4'd0};
    tbl[5]  = '{1'b1, 7'b1111000, 4'd3, 4'd0};
    tbl[6]  = '{1'b1, 7'b1110000, 4'd4, 4'd0};
    tbl[7]  = '{1'b1, 7'b1010000, 4'd5, 4'd0};
    tbl[8]  = '{1'b1, 7'b1110000, 4'd6, 4'd0};
    tbl[9]  = '{1'b1, 7'b1111100, 4'd0, 4'd1};
    tbl[10] = '{1'b0, 7'b0110000, 4'd0, 4'd0};
    tbl[11] = '{1'b0, 7'b0110000, 4'd0, 4'd0};
    tbl[12] = '{1'b1, 7'b1111110, 4'd0, 4'd0};
    tbl[13] = '{1'b1, 7'b1111000, 4'd1, 4'd0};

    // Reset held with en high: everything at reset values
    rst = 1'b0; en_a = 1'b1; en_s = 1'b0;
    repeat (3) tick();
    chk("rst_def", 64'(d_vec), 64'(D_RST));
    chk("rst_mid", 64'(m_vec), 64'(D_RST));
    chk("rst_pol", 64'(p_inv), 64'(D_RST));
    chk("rst_pol_hs", 64'({p_hs, p_vs}), 64'd0);
    chk("rst_sml", 64'(s_vec), 64'({7'b0110000, 8'd0}));
    chk("rst_req", 64'({d_rv, d_rc, d_rr}), 64'd0);

    // Release reset: first pix_ce after DIV clks, then every second clk
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!d_pix && n < 10);
    chk("first_pix_lat", 64'(n), 64'd2);
    chk("first_pix_vec", 64'(d_vec), 64'(D_START));
`ifdef VGA_PREFETCH_EN
    chk("pf_first", 64'({d_rv, d_rc, d_rr}), 64'({1'b1, 11'd2, 11'd0}));
`else
    chk("pf_off", 64'({d_rv, d_rc, d_rr}), 64'd0);
`endif
    tick();
    chk("pix_gap", 64'({d_pix, d_col}), 64'({1'b0, 11'd0}));
    tick();
    chk("col1", 64'({d_pix, d_ls, d_fs, d_col}), 64'({3'b100, 11'd1}));
    tick(); tick();
    chk("col2", 64'({d_pix, d_col}), 64'({1'b1, 11'd2}));

    // Table-driven small raster incl. en drop/re-enable
    for (int i = 0; i < 14; i++) begin
      en_s = tbl[i].en;
      tick();
      chk($sformatf("tbl%0d", i), 64'(s_vec), 64'({tbl[i].flg, tbl[i].col, tbl[i].row}));
    end

    // Small raster: frame_end position, one full frame of counts
    n = 0;
    while (!s_fe && n < 100) begin tick(); n++; end
    chk("s_fe_pos", 64'({s_fe, s_col, s_row}), 64'({1'b1, 4'd3, 4'd2}));
    n = 0;
    while (!s_fs && n < 100) begin tick(); n++; end
    chk("s_fs_found", 64'(s_fs), 64'd1);
    n = 0; blanks = 0; vlow = 0; lsn = 0; fen = 0; bad = 0; rqbad = 0;
    do begin
      tick(); n++;
      if (s_blank) blanks++;
      if (!s_vs) vlow++;
      if ((!s_vs) != (s_row == 4'd4)) bad++;
      if (s_ls) lsn++;
      if (s_fe) fen++;
`ifdef VGA_PREFETCH_EN
      if ({31'd0, s_rv, 16'(s_rc), 16'(s_rr)} != f_lead(32'(s_col), 32'(s_row), 7, 6, 4, 3)) rqbad++;
`else
      if ({s_rv, s_rc, s_rr} != '0) rqbad++;
`endif
    end while (!s_fs && n < 100);
    chk("s_frame_period", 64'(n), 64'd42);
    chk("s_fs_with_ls", 64'({s_fs, s_ls}), 64'b11);
    chk("s_blank_clks", 64'(blanks), 64'd12);
    chk("s_vs_clks", 64'(vlow), 64'd7);
    chk("s_vs_rows", 64'(bad), 64'd0);
    chk("s_ls_count", 64'(lsn), 64'd6);
    chk("s_fe_count", 64'(fen), 64'd1);
    chk("s_req", 64'(rqbad), 64'd0);

    // Default: hs low 192 clks from col 656 to col 752
    n = 0;
    while (d_hs && n < 2000) begin tick(); n++; end
    chk("hs_fall", 64'({d_hs, d_col}), 64'({1'b0, 11'd656}));
    n = 0;
    while (!d_hs && n < 2000) begin tick(); n++; end
    chk("hs_width", 64'(n), 64'd192);
    chk("hs_rise_col", 64'(d_col), 64'd752);
    n = 0;
    while (!d_ls && n < 2000) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (!d_ls && n < 4000);
    chk("line_period", 64'(n), 64'd1600);

    // Short-frame instance: one frame of vertical timing, polarity twin compared
    n = 0;
    while (!m_fs && n < 20000) begin tick(); n++; end
    chk("m_fs_found", 64'(m_fs), 64'd1);
    n = 0; blanks = 0; vlow = 0; lsn = 0; fen = 0; febad = 0; bad = 0; rqbad = 0; fsnols = 0;
    do begin
      tick(); n++;
      if (m_blank) blanks++;
      if (!m_vs) vlow++;
      if ((!m_vs) != (m_row == 11'd6 || m_row == 11'd7)) bad++;
      if (p_inv != m_vec || {p_rv, p_rc, p_rr} != {m_rv, m_rc, m_rr}) fsnols++;
      if (m_ls) lsn++;
      if (m_fe) begin
        fen++;
        if (m_col != 11'd639 || m_row != 11'd3) febad++;
      end
`ifdef VGA_PREFETCH_EN
      if (m_pix) begin
        if ({31'd0, m_rv, 16'(m_rc), 16'(m_rr)} != f_lead(32'(m_col), 32'(m_row), 800, 10, 640, 4)) rqbad++;
        if (m_col == 11'd638 && m_row == 11'd3) chk("pf_638", 64'(m_rv), 64'd0);
        if (m_col == 11'd798 && m_row == 11'd9) chk("pf_wrap", 64'({m_rc, m_rr}), 64'd0);
      end
`else
      if ({m_rv, m_rc, m_rr, p_rv, p_rc, p_rr} != '0) rqbad++;
`endif
    end while (!m_fs && n < 20000);
    chk("m_frame_period", 64'(n), 64'd16000);
    chk("m_blank_clks", 64'(blanks), 64'd5120);
    chk("m_vs_clks", 64'(vlow), 64'd3200);
    chk("m_vs_rows", 64'(bad), 64'd0);
    chk("pol_twin", 64'(fsnols), 64'd0);
    chk("m_ls_count", 64'(lsn), 64'd10);
    chk("m_fe_count", 64'(fen), 64'd1);
    chk("m_fe_pos", 64'(febad), 64'd0);
    chk("m_req", 64'(rqbad), 64'd0);

    // Drop en at (300,3), hold low 10 clks, re-enable
    n = 0;
    while (!(m_pix && m_col == 11'd300 && m_row == 11'd3) && n < 40000) begin tick(); n++; end
    chk("drop_pos", 64'({m_pix, m_col, m_row}), 64'({1'b1, 11'd300, 11'd3}));
    en_a = 1'b0;
    tick();
    chk("drop_mid", 64'(m_vec), 64'(D_RST));
    chk("drop_def", 64'(d_vec), 64'(D_RST));
    bad = 0;
    repeat (9) begin
      tick();
      if (m_vec != D_RST || d_vec != D_RST || p_inv != D_RST || {m_rv, m_rc, m_rr} != '0) bad++;
    end
    chk("drop_hold", 64'(bad), 64'd0);
    en_a = 1'b1;
    n = 0; bad = 0;
    do begin
      tick(); n++;
      if (!m_pix && (m_ls || m_fs || m_fe || m_blank)) bad++;
    end while (!m_pix && n < 10);
    chk("reen_lat", 64'(n), 64'd2);
    chk("reen_stale", 64'(bad), 64'd0);
    chk("reen_vec", 64'(m_vec), 64'(D_START));
`ifdef VGA_PREFETCH_EN
    chk("reen_pf", 64'({m_rv, m_rc, m_rr}), 64'({1'b1, 11'd2, 11'd0}));
`endif

    // Asynchronous reset mid-line forces reset values immediately
    repeat (7) tick();
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_mid", 64'(m_vec), 64'(D_RST));
    chk("async_rst_pol", 64'(p_inv), 64'(D_RST));
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!m_pix && n < 10);
    chk("post_rst_lat", 64'(n), 64'd2);
    chk("post_rst_vec", 64'(m_vec), 64'(D_START));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
